// File: rtl/mvau_defn.sv
// rtl/mvau_defn.sv - shared MVAU folding helpers (SF, NF, pointer widths)
package mvau_defn;

    // Words per input vector: lowered matrix width folded over SIMD lanes.
    function automatic int calc_sf(input int matrix_w, input int simd);
        return matrix_w / simd;
    endfunction

    // Replays per vector: matrix height folded over the PEs.
    function automatic int calc_nf(input int matrix_h, input int pe);
        return matrix_h / pe;
    endfunction

    // Counter width for a count of n values; never below one bit so n=1 still elaborates.
    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvau_inp_bank.sv
// rtl/mvau_inp_bank.sv - one SF x TI activation bank, sync write, async read
//
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write word index
//   wdata - word to store
//   raddr - read word index
//   rdata - word at raddr (combinational)
module mvau_inp_bank #(
    parameter int DEPTH = 4,
    parameter int TI    = 8,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [TI-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [TI-1:0] rdata
);

    // Contents are deliberately not reset; the full flags in the controller
    // decide whether anything here is meaningful.
    logic [TI-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mvau_inp_pingpong_buffer.sv
// rtl/mvau_inp_pingpong_buffer.sv - two-bank input buffer replaying each vector NF times
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   in_v, in     - incoming activation word and its valid
//   in_rdy       - a word is accepted this cycle when in_v & in_rdy
//   out_v, out   - buffered word and its valid
//   out_rdy      - downstream takes the word this cycle
//   out_last_sf  - out is the last word (SF-1) of the current replay
//   out_last     - out is the last word of the last replay; the bank is released after it
module mvau_inp_pingpong_buffer
    import mvau_defn::*;
#(
    parameter int TI      = 8,
    parameter int MatrixW = 8,
    parameter int MatrixH = 6,
    parameter int SIMD    = 2,
    parameter int PE      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    input  logic [TI-1:0] in,
    output logic          in_rdy,
    output logic          out_v,
    output logic [TI-1:0] out,
    input  logic          out_rdy,
    output logic          out_last_sf,
    output logic          out_last
);

    localparam int SF = calc_sf(MatrixW, SIMD);
    localparam int NF = calc_nf(MatrixH, PE);
    localparam int AW = ptr_width(SF);
    localparam int RW = ptr_width(NF);

    localparam logic [AW-1:0] SF_LAST = AW'(SF - 1);
    localparam logic [RW-1:0] NF_LAST = RW'(NF - 1);

    generate
        if ((MatrixW % SIMD) != 0 || (MatrixH % PE) != 0) begin : g_bad_fold
            $error("mvau_inp_pingpong_buffer: MatrixW must divide by SIMD and MatrixH by PE");
        end
    endgenerate

    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;

    logic          wr_fire;
    logic          rd_fire;
    logic          rd_last_sf;
    logic          rd_last_rep;
    logic [TI-1:0] bank_rdata [2];

    // in_rdy looks only at registered flags, so a bank released this cycle
    // cannot be written until the next one.
    assign in_rdy      = !full_q[wr_bank_q];
    assign out_v       = full_q[rd_bank_q];
    assign wr_fire     = in_v && in_rdy;
    assign rd_fire     = out_v && out_rdy;
    assign rd_last_sf  = (rd_addr_q == SF_LAST);
    assign rd_last_rep = (rep_cnt_q == NF_LAST);

    assign out         = bank_rdata[rd_bank_q];
    assign out_last_sf = out_v && rd_last_sf;
    assign out_last    = out_v && rd_last_sf && rd_last_rep;

    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rep_cnt_d = rep_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;

        // Release first: the read bank is full and the completing write bank
        // is empty, so the two never target the same flag in one cycle.
        if (rd_fire) begin
            if (rd_last_sf) begin
                rd_addr_d = '0;
                if (rd_last_rep) begin
                    rep_cnt_d         = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end

        if (wr_fire) begin
            if (wr_addr_q == SF_LAST) begin
                wr_addr_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rep_cnt_q <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rep_cnt_q <= rep_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mvau_inp_bank #(
            .DEPTH (SF),
            .TI    (TI),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank_q == 1'(b))),
            .waddr (wr_addr_q),
            .wdata (in),
            .raddr (rd_addr_q),
            .rdata (bank_rdata[b])
        );
    end

endmodule

// File: doc/mvau_inp_pingpong_buffer.md
MVAU_INP_PINGPONG_BUFFER -- requirements
Module: mvau_inp_pingpong_buffer

Interface
REQ-001 SHALL have parameter TI, default 8: input word width (SIMD*TSrcI) in bits.
REQ-002 SHALL have parameter MatrixW, default 8: lowered weight matrix width (Kernel^2*IFMCh).
REQ-003 SHALL have parameter MatrixH, default 6: lowered weight matrix height (OFMCh).
REQ-004 SHALL have parameter SIMD, default 2: input lanes per word; SF=MatrixW/SIMD words per vector.
REQ-005 SHALL have parameter PE, default 2: processing elements; NF=MatrixH/PE replays per vector.
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port in_v, input, 1: input word valid.
REQ-009 SHALL have port in, input, TI: input activation word.
REQ-010 SHALL have port in_rdy, output, 1: buffer accepts a word this cycle.
REQ-011 SHALL have port out_v, output, 1: output word valid.
REQ-012 SHALL have port out, output, TI: buffered activation word.
REQ-013 SHALL have port out_rdy, input, 1: downstream consumes a word this cycle.
REQ-014 SHALL have port out_last_sf, output, 1: out is word SF-1 of the current replay.
REQ-015 SHALL have port out_last, output, 1: out is word SF-1 of replay NF-1 (vector release).

Function
REQ-016 SHALL hold two banks of SF words x TI bits; state per bank: full flag.
REQ-017 Write side SHALL accept in when in_v&in_rdy, storing at wr_addr of bank wr_bank; in_rdy = !full[wr_bank].
REQ-018 wr_addr SHALL increment per accepted word; at SF-1 it SHALL wrap to 0, set full[wr_bank], toggle wr_bank.
REQ-019 Read side: out_v = full[rd_bank]; out = bank[rd_bank][rd_addr], combinational from registered pointers (zero latency from full set to out_v next cycle).
REQ-020 On out_v&out_rdy, rd_addr SHALL increment; at SF-1 it SHALL wrap to 0 and rep_cnt SHALL increment.
REQ-021 When rd_addr=SF-1 and rep_cnt=NF-1 are consumed, SHALL clear full[rd_bank], reset rep_cnt to 0, toggle rd_bank.
REQ-022 Words SHALL be emitted in order 0..SF-1, NF times per vector; vectors emitted in arrival order.
REQ-023 Fill of one bank SHALL overlap replay of the other; both full -> in_rdy=0 until a release.
REQ-024 Simultaneous completing write and releasing read on different banks SHALL both take effect that cycle.
REQ-025 Release of a bank SHALL not make in_rdy rise before the next cycle (no same-cycle write into released bank).
REQ-026 out_v low SHALL freeze rd_addr and rep_cnt; in_v low SHALL freeze wr_addr.
REQ-027 SF=1 and NF=1 SHALL be legal; pointer widths SHALL be max(1,$clog2(SF)) and max(1,$clog2(NF)).
REQ-028 MatrixW%SIMD!=0 or MatrixH%PE!=0 SHALL be a elaboration-time error.

Reset
REQ-029 rst SHALL asynchronously clear wr_addr, rd_addr, rep_cnt, wr_bank, rd_bank, both full flags.
REQ-030 During and after reset: in_rdy=1, out_v=0, out_last_sf=0, out_last=0; memory contents not reset.
REQ-031 rst asserted mid-fill or mid-replay SHALL discard all buffered vectors.

Structure
REQ-032 SF, NF, pointer-width computation functions SHALL live in the shared mvau_defn package.
REQ-033 Storage SHALL be one sub-module mvau_inp_bank (SF x TI, one write port, one async read port), instantiated twice.
REQ-034 Control (pointers, flags, counters) SHALL be in the top module; no other sub-modules.

Verification (TI=8, SF=4, NF=3)
REQ-035 Reset then write 0x10..0x13 with out_rdy=1 -> out sequence 0x10..0x13 x3 (12 words), out_last_sf on words 4,8,12, out_last on word 12 only.
REQ-036 Write 0x10..0x13 then 0x20..0x23 back-to-back, out_rdy=0 -> in_rdy=0 after 8th word, out_v=1, out=0x10.
REQ-037 Continuous in_v, out_rdy=1 -> first vector replays while second fills; 0x20 replay starts cycle after 0x13 third replay, no gap.
REQ-038 Random out_rdy toggling 50% -> output order identical to REQ-035, no word dropped or repeated.
REQ-039 Assert rst after 2nd replay word of vector 0 -> out_v=0, in_rdy=1 immediately; new vector 0x30..0x33 replays cleanly.
REQ-040 SF=1, NF=1 build: write 0x55 -> single out 0x55 with out_last_sf=out_last=1, bank released next cycle.
